dmem_arbiter: RTL and testbench

Two-port arbiter and owner of the 8 x 32-bit data memory. It shares the single memory between the processor datapath's load/store path (CPU port) and the program/data loader (LDR port). Grants use round-robin on ties, and the loader can lock the memory for a burst. The CPU port gets a stall indication so the datapath can hold its PC while it waits.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_arbiter_rr_pick2.sv | 17 +
 rtl/dmem_arbiter.sv | 104 ++++++++++
 tb/tb_dmem_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: port ids, arbitration mode
// and default geometry.
package dmem_arb_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 3;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    typedef enum logic {
        MODE_RR     = 1'b0,
        MODE_LOCKED = 1'b1
    } mode_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-input round-robin picker. Bit 0 is the CPU port and bit 1 is the loader
// port. On a tie, the port that was not granted last wins.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | (last == PORT_LDR));
        gnt[1] = req[1] & (~req[0] | (last == PORT_CPU));
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Owner of the 8 x 32 data memory. It arbitrates between the CPU load/store
// path and the loader, and lets the loader lock the memory for a burst.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [DW-1:0] ldr_rdata,
    input  logic          ldr_lock
);

    mode_e         mode_q, mode_d;
    logic          last_gnt_q, last_gnt_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic          ldr_rvalid_q, ldr_rvalid_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
    logic [DW-1:0] mem_q [2**AW];

    logic          lock_hold;
    logic          rr_last;
    logic [1:0]    rr_gnt;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    // The lock only holds while ldr_lock stays high. The cycle in which it
    // drops is arbitrated as RR with the loader counted as last, so a waiting
    // CPU gets in first.
    assign lock_hold = (mode_q == MODE_LOCKED) && ldr_lock;
    assign rr_last   = (mode_q == MODE_LOCKED) ? PORT_LDR : last_gnt_q;

    rr_pick2 u_pick (
        .req  ({ldr_req, cpu_req}),
        .last (rr_last),
        .gnt  (rr_gnt)
    );

    always_comb begin
        cpu_gnt      = lock_hold ? 1'b0 : rr_gnt[0];
        ldr_gnt      = lock_hold ? ldr_req : rr_gnt[1];
        cpu_stall    = cpu_req & ~cpu_gnt;

        mode_d       = (ldr_lock && ((mode_q == MODE_LOCKED) || ldr_gnt)) ? MODE_LOCKED : MODE_RR;
        last_gnt_d   = cpu_gnt ? PORT_CPU : (ldr_gnt ? PORT_LDR : last_gnt_q);

        wr_en        = (cpu_gnt & cpu_we) | (ldr_gnt & ldr_we);
        wr_addr      = cpu_gnt ? cpu_addr : ldr_addr;
        wr_data      = cpu_gnt ? cpu_wdata : ldr_wdata;

        cpu_rvalid_d = cpu_gnt & ~cpu_we;
        ldr_rvalid_d = ldr_gnt & ~ldr_we;
        cpu_rdata_d  = cpu_rvalid_d ? mem_q[cpu_addr] : cpu_rdata_q;
        ldr_rdata_d  = ldr_rvalid_d ? mem_q[ldr_addr] : ldr_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= MODE_RR;
            last_gnt_q   <= PORT_LDR;
            cpu_rvalid_q <= 1'b0;
            ldr_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            mode_q       <= mode_d;
            last_gnt_q   <= last_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            ldr_rvalid_q <= ldr_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ldr_rdata_q  <= ldr_rdata_d;
        end
    end

    // Memory contents survive reset, but no write may commit in a reset cycle.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign ldr_rvalid = ldr_rvalid_q;
    assign ldr_rdata  = ldr_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Inputs change 1 time unit after each rising
// edge and outputs are checked 1 time unit later.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
    logic [2:0]  cpu_addr, ldr_addr;
    logic [31:0] cpu_wdata, ldr_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, ldr_gnt, ldr_rvalid;
    logic [31:0] cpu_rdata, ldr_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_gnt    (ldr_gnt),
        .ldr_rvalid (ldr_rvalid),
        .ldr_rdata  (ldr_rdata),
        .ldr_lock   (ldr_lock)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0; ldr_lock = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_ldr_rdata", ldr_rdata, 32'd0);

        // Both load at once: CPU wins the first tie, loader follows.
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 0;
        ldr_req = 1; ldr_we = 0; ldr_addr = 1;
        #1;
        chk("t1_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("t1_ldr_gnt", 32'(ldr_gnt), 32'd0);
        chk("t1_cpu_stall", 32'(cpu_stall), 32'd0);
        tick();
        cpu_req = 0;
        #1;
        chk("t1_ldr_gnt_next", 32'(ldr_gnt), 32'd1);
        chk("t1_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        tick();
        ldr_req = 0;
        #1;
        chk("t1_ldr_rvalid", 32'(ldr_rvalid), 32'd1);
        chk("t1_cpu_rvalid_pulse", 32'(cpu_rvalid), 32'd0);

        // CPU store then load of addr 2.
        tick();
        cpu_req = 1; cpu_we = 1; cpu_addr = 2; cpu_wdata = 32'h7;
        #1;
        chk("t2_store_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        cpu_we = 0;
        #1;
        chk("t2_load_gnt", 32'(cpu_gnt), 32'd1);
        chk("t2_store_no_rvalid", 32'(cpu_rvalid), 32'd0);
        tick();
        cpu_req = 0;
        #1;
        chk("t2_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("t2_cpu_rdata", cpu_rdata, 32'h7);
        chk("t2_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
        tick();
        chk("t2_rvalid_pulse", 32'(cpu_rvalid), 32'd0);

        // Loader store to addr 7 leaves last_gnt=LDR, then 6 tied loads.
        ldr_req = 1; ldr_we = 1; ldr_addr = 7; ldr_wdata = 32'h55;
        tick();
        ldr_we = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 2;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("t3_cpu_gnt_%0d", i), 32'(cpu_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t3_ldr_gnt_%0d", i), 32'(ldr_gnt), (i % 2 == 0) ? 32'd0 : 32'd1);
            chk($sformatf("t3_cpu_stall_%0d", i), 32'(cpu_stall), (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
        end
        cpu_req = 0; ldr_req = 0;
        #1;
        chk("t3_ldr_rvalid", 32'(ldr_rvalid), 32'd1);
        chk("t3_ldr_rdata", ldr_rdata, 32'h55);
        chk("t3_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("t3_cpu_rdata_hold", cpu_rdata, 32'h7);

        // CPU load leaves last_gnt=CPU; loader then locks and bursts 4 stores.
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 2;
        tick();
        cpu_addr = 3;
        ldr_req = 1; ldr_we = 1; ldr_lock = 1;
        for (int i = 0; i < 4; i++) begin
            ldr_addr = 3'(i);
            ldr_wdata = 32'hA + 32'(i);
            #1;
            chk($sformatf("t4_ldr_gnt_%0d", i), 32'(ldr_gnt), 32'd1);
            chk($sformatf("t4_cpu_gnt_%0d", i), 32'(cpu_gnt), 32'd0);
            chk($sformatf("t4_cpu_stall_%0d", i), 32'(cpu_stall), 32'd1);
            tick();
        end
        ldr_req = 0; ldr_we = 0; ldr_lock = 0;
        #1;
        chk("t4_unlock_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("t4_unlock_stall", 32'(cpu_stall), 32'd0);
        tick();
        cpu_req = 0;
        #1;
        chk("t4_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("t4_cpu_rdata", cpu_rdata, 32'hD);
        ldr_req = 1; ldr_addr = 0;
        tick();
        ldr_req = 0;
        #1;
        chk("t4_mem0", ldr_rdata, 32'hA);

        // Lock with an idle loader: CPU store of addr 0 must not get through.
        tick();
        ldr_req = 1; ldr_we = 0; ldr_addr = 1; ldr_lock = 1;
        #1;
        chk("t5_lock_gnt", 32'(ldr_gnt), 32'd1);
        tick();
        ldr_req = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 0; cpu_wdata = 32'hFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t5_cpu_gnt_%0d", i), 32'(cpu_gnt), 32'd0);
            chk($sformatf("t5_cpu_stall_%0d", i), 32'(cpu_stall), 32'd1);
            chk($sformatf("t5_ldr_gnt_%0d", i), 32'(ldr_gnt), 32'd0);
            tick();
        end
        ldr_req = 1; ldr_we = 0; ldr_addr = 0;
        #1;
        chk("t5_ldr_gnt_locked", 32'(ldr_gnt), 32'd1);
        tick();
        ldr_we = 1; ldr_addr = 1; ldr_wdata = 32'hEE;
        #1;
        chk("t5_mem0_unchanged", ldr_rdata, 32'hA);

        // Reset while locked with both requests held.
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("t6_ldr_rdata_rst", ldr_rdata, 32'd0);
        chk("t6_ldr_rvalid_rst", 32'(ldr_rvalid), 32'd0);
        chk("t6_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("t6_ldr_gnt", 32'(ldr_gnt), 32'd0);
        tick();
        cpu_req = 0; ldr_lock = 0;
        ldr_we = 0; ldr_addr = 1;
        tick();
        ldr_req = 0;
        #1;
        chk("t6_no_write_in_reset", ldr_rdata, 32'hB);
        cpu_req = 1; cpu_we = 0; cpu_addr = 0;
        tick();
        cpu_req = 0;
        #1;
        chk("t6_cpu_store_after_reset", cpu_rdata, 32'hFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
